// File: rtl/instruction_parser_if.sv
// Byte-in / instruction-out signal bundle between the deserializer, the parser and the
// instruction buffer write port.
interface instruction_parser_if #(
  parameter int INSTRUCTION_WIDTH = 42
);
  // Neither side has a ready: a byte is taken on every cycle inbound_valid is high, and a word
  // is written on every cycle outbound_valid is high.
  logic                         inbound_valid;
  logic [7:0]                   inbound_data;
  logic                         outbound_valid;
  logic                         outbound_last;
  logic [INSTRUCTION_WIDTH-1:0] outbound_data;
  logic [15:0]                  instr_count;
  logic                         parse_error;

  modport master (
    output inbound_valid, inbound_data,
    input  outbound_valid, outbound_last, outbound_data, instr_count, parse_error
  );

  modport slave (
    input  inbound_valid, inbound_data,
    output outbound_valid, outbound_last, outbound_data, instr_count, parse_error
  );
endinterface

// File: rtl/instruction_parser.sv
// Parses "turn on|turn off|toggle X0,Y0 through X1,Y1" lines into {op,x0,y0,x1,y1} words,
// holding one word back so the final word can carry outbound_last.
module instruction_parser #(
  parameter int         COORD_WIDTH       = 10,
  parameter int         INSTRUCTION_WIDTH = 2 + 4 * COORD_WIDTH,
  parameter logic [7:0] EOT_CHAR          = 8'h04
) (
  input  logic               clk,
  input  logic               reset_n,
  instruction_parser_if.slave bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {OP_SCAN, NUM_SCAN, FLUSH, DONE} state_e;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_O  = 8'h6F;
  localparam logic [7:0] CH_N  = 8'h6E;
  localparam logic [7:0] CH_F  = 8'h66;

  state_e                       state_q, state_d;
  logic [2:0]                   cidx_q, cidx_d;
  logic [1:0]                   op_q, op_d;
  logic [COORD_WIDTH-1:0]       fld_q [4];
  logic [COORD_WIDTH-1:0]       fld_d [4];
  logic [2:0]                   fidx_q, fidx_d;
  logic                         dig_q, dig_d;
  logic                         hold_vld_q, hold_vld_d;
  logic [INSTRUCTION_WIDTH-1:0] hold_q, hold_d;
  logic                         ov_q, ov_d;
  logic                         ol_q, ol_d;
  logic [INSTRUCTION_WIDTH-1:0] od_q, od_d;
  logic [15:0]                  cnt_q, cnt_d;
  logic                         err_q, err_d;

  logic                         accept;
  logic                         is_digit;
  logic                         is_eot;
  logic                         line_end;
  logic                         line_complete;
  logic [INSTRUCTION_WIDTH-1:0] word;
  logic [COORD_WIDTH+3:0]       acc;

  always_comb begin
    accept        = bus.inbound_valid && (state_q == OP_SCAN || state_q == NUM_SCAN);
    is_digit      = bus.inbound_data >= 8'h30 && bus.inbound_data <= 8'h39;
    is_eot        = bus.inbound_data == EOT_CHAR;
    line_end      = is_eot || bus.inbound_data == CH_LF;
    // The last field has no trailing separator, so a digit in field 3 completes the line.
    line_complete = fidx_q == 3'd4 || (fidx_q == 3'd3 && dig_q);
    word          = {op_q, fld_q[0], fld_q[1], fld_q[2], fld_q[3]};
    acc           = (COORD_WIDTH+4)'(fld_q[fidx_q[1:0]]) * (COORD_WIDTH+4)'(10)
                  + (COORD_WIDTH+4)'(bus.inbound_data - 8'h30);

    state_d    = state_q;
    cidx_d     = cidx_q;
    op_d       = op_q;
    fld_d      = fld_q;
    fidx_d     = fidx_q;
    dig_d      = dig_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ov_d       = 1'b0;
    ol_d       = ol_q;
    od_d       = od_q;
    err_d      = err_q;

    if (accept && bus.inbound_data != CH_CR) begin
      if (line_end) begin
        if (cidx_q != 3'd0) begin
          if (line_complete) begin
            if (hold_vld_q) begin
              ov_d = 1'b1;
              od_d = hold_q;
            end
            hold_d     = word;
            hold_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        cidx_d  = '0;
        fld_d   = '{default: '0};
        fidx_d  = '0;
        dig_d   = 1'b0;
        state_d = is_eot ? FLUSH : OP_SCAN;
      end else begin
        cidx_d = (cidx_q == 3'd7) ? cidx_q : cidx_q + 3'd1;
        if (state_q == OP_SCAN) begin
          if (cidx_q == 3'd1 && bus.inbound_data == CH_O) begin
            op_d    = 2'b10;
            state_d = NUM_SCAN;
          end else if (cidx_q == 3'd6 && bus.inbound_data == CH_N) begin
            op_d    = 2'b01;
            state_d = NUM_SCAN;
          end else if (cidx_q == 3'd6 && bus.inbound_data == CH_F) begin
            op_d    = 2'b00;
            state_d = NUM_SCAN;
          end
        end else if (fidx_q < 3'd4) begin
          if (is_digit) begin
            fld_d[fidx_q[1:0]] = acc[COORD_WIDTH-1:0];
            dig_d              = 1'b1;
          end else if (dig_q) begin
            fidx_d = fidx_q + 3'd1;
            dig_d  = 1'b0;
          end
        end
      end
    end

    // Inbound bytes are dropped from here on; the held word (if any) goes out as the last one.
    if (state_q == FLUSH) begin
      if (hold_vld_q) begin
        ov_d       = 1'b1;
        ol_d       = 1'b1;
        od_d       = hold_q;
        hold_vld_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      state_d = DONE;
    end

    cnt_d = ov_d ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OP_SCAN;
      cidx_q     <= '0;
      op_q       <= '0;
      fld_q      <= '{default: '0};
      fidx_q     <= '0;
      dig_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
      od_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cidx_q     <= cidx_d;
      op_q       <= op_d;
      fld_q      <= fld_d;
      fidx_q     <= fidx_d;
      dig_q      <= dig_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      ov_q       <= ov_d;
      ol_q       <= ol_d;
      od_q       <= od_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.outbound_valid = ov_q;
  assign bus.outbound_last  = ol_q;
  assign bus.outbound_data  = od_q;
  assign bus.instr_count    = cnt_q;
  assign bus.parse_error    = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_instruction_parser.sv
// Directed bench for instruction_parser: byte streams in, captured beats compared against
// hand-computed instruction words.
module tb_instruction_parser;
  localparam int W = 42;
  localparam logic [7:0] EOT = 8'h04;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;
  int         cyc;
  int         checks;
  int         errors;
  int         last_cyc;
  int         nl2_cyc;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  int           got_cyc[$];

  instruction_parser_if #(.INSTRUCTION_WIDTH(W)) bus ();

  instruction_parser dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output capture
  always @(negedge clk) begin
    if (reset_n && bus.outbound_valid) begin
      got_data.push_back(bus.outbound_data);
      got_last.push_back(bus.outbound_last);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [W-1:0] mk(input logic [1:0] op, input int a, input int b,
                                      input int c, input int d);
    logic [9:0] fa, fb, fc, fd;
    fa = 10'(a); fb = 10'(b); fc = 10'(c); fd = 10'(d);
    return {op, fa, fb, fc, fd};
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    bus.inbound_valid = 1'b1;
    bus.inbound_data  = b;
    @(negedge clk);
    bus.inbound_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.outbound_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.outbound_valid); end
    if (bus.outbound_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", bus.outbound_last); end
    if (bus.outbound_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.outbound_data); end
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.instr_count); end
    if (bus.parse_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", bus.parse_error); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  // Checks the test-1 outcome; used by the single-line, post-reset and CR/LF scenarios.
  task automatic test_single(input string tag, input int max_gap, input logic trailing);
    exp_q.push_back(mk(2'b01, 0, 0, 999, 999));
    if (max_gap > 0) send_str("\r\n", max_gap);
    if (max_gap > 0) send_str("turn on 0,0 through 999,999\r\n", max_gap);
    else send_str("turn on 0,0 through 999,999\n", 0);
    send_byte(EOT);
    if (trailing) send_str("toggle 1,1 through 2,2\n", 0);
    if (trailing) send_byte(EOT);
    settle();
    checks += 6;
    if (got_data.size() != 1) begin errors++; $display("FAIL %s_beats got=%0d exp=1", tag, got_data.size()); end
    if (got_data.size() < 1 || got_data[0] !== exp_q[0]) begin
      errors++; $display("FAIL %s_data got=%h exp=%h", tag, got_data.size() > 0 ? got_data[0] : '0, exp_q[0]);
    end
    if (got_last.size() < 1 || got_last[0] !== 1'b1) begin errors++; $display("FAIL %s_beat_last exp=1", tag); end
    if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL %s_count got=%0d exp=1", tag, bus.instr_count); end
    if (bus.parse_error !== 1'b0) begin errors++; $display("FAIL %s_error got=%b exp=0", tag, bus.parse_error); end
    if (bus.outbound_last !== 1'b1) begin errors++; $display("FAIL %s_last_sticky got=%b exp=1", tag, bus.outbound_last); end
  endtask

  task automatic test_three_lines();
    do_reset();
    exp_q.push_back(mk(2'b10, 1, 2, 3, 4));
    exp_q.push_back(mk(2'b00, 5, 6, 7, 8));
    exp_q.push_back(mk(2'b01, 9, 10, 11, 12));
    send_str("toggle 1,2 through 3,4\n", 0);
    send_str("turn off 5,6 through 7,8\n", 0);
    nl2_cyc = last_cyc;
    send_str("turn on 9,10 through 11,12\n", 0);
    send_byte(EOT);
    settle();
    checks += 3;
    if (got_data.size() != 3) begin errors++; $display("FAIL three_beats got=%0d exp=3", got_data.size()); end
    if (got_cyc.size() < 1 || got_cyc[0] != nl2_cyc) begin
      errors++; $display("FAIL three_first_cycle got=%0d exp=%0d", got_cyc.size() > 0 ? got_cyc[0] : -1, nl2_cyc);
    end
    if (bus.instr_count !== 16'd3) begin errors++; $display("FAIL three_count got=%0d exp=3", bus.instr_count); end
    for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL three_data[%0d] got=%h exp=%h", i, i < got_data.size() ? got_data[i] : '0, exp_q[i]);
      end
      if (i >= got_last.size() || got_last[i] !== (i == 2)) begin
        errors++; $display("FAIL three_last[%0d] exp=%0d", i, i == 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(mk(2'b10, 1, 1, 2, 2));
    exp_q.push_back(mk(2'b10, 3, 3, 4, 4));
    send_str("toggle 1,1 through 2,2\ntoggle 3,3 through 4,4", 0);
    send_byte(EOT);
    settle();
    checks += 3;
    if (got_data.size() != 2) begin errors++; $display("FAIL b2b_beats got=%0d exp=2", got_data.size()); end
    if (got_cyc.size() < 2 || got_cyc[1] != got_cyc[0] + 1) begin errors++; $display("FAIL b2b_adjacent beats not on consecutive cycles"); end
    if (got_last.size() < 2 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin errors++; $display("FAIL b2b_last exp=0,1"); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, i < got_data.size() ? got_data[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_malformed();
    do_reset();
    exp_q.push_back(mk(2'b01, 1, 2, 3, 4));
    exp_q.push_back(mk(2'b00, 6, 7, 8, 9));
    send_str("turn on 1,2 through 3,4\ntoggle 5,5\n", 0);
    checks++;
    if (bus.parse_error !== 1'b1) begin errors++; $display("FAIL malformed_error_early got=%b exp=1", bus.parse_error); end
    send_str("turn off 6,7 through 8,9\n", 0);
    send_byte(EOT);
    settle();
    checks += 2;
    if (bus.instr_count !== 16'd2) begin errors++; $display("FAIL malformed_count got=%0d exp=2", bus.instr_count); end
    if (bus.parse_error !== 1'b1) begin errors++; $display("FAIL malformed_error got=%b exp=1", bus.parse_error); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i]) begin
        errors++; $display("FAIL malformed_data[%0d] got=%h exp=%h", i, i < got_data.size() ? got_data[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_str("toggle 1,1 through 2,2\nturn on 3,3 through 4,4\nturn of", 0);
    checks++;
    if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL areset_pre_count got=%0d exp=1", bus.instr_count); end
    #2 reset_n = 1'b0;
    #1;
    checks += 4;
    if (bus.outbound_data !== '0) begin errors++; $display("FAIL areset_data got=%h exp=0", bus.outbound_data); end
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", bus.instr_count); end
    if (bus.outbound_valid !== 1'b0 || bus.outbound_last !== 1'b0) begin errors++; $display("FAIL areset_strobes got=%b%b exp=00", bus.outbound_valid, bus.outbound_last); end
    if (bus.parse_error !== 1'b0) begin errors++; $display("FAIL areset_error got=%b exp=0", bus.parse_error); end
    @(negedge clk);
    reset_n = 1'b1;
    got_data.delete(); got_last.delete(); got_cyc.delete(); exp_q.delete();
    @(negedge clk);
    test_single("areset_t1", 0, 1'b0);
  endtask

  task automatic test_empty();
    do_reset();
    send_str("\n", 0);
    send_byte(EOT);
    settle();
    checks += 4;
    if (got_data.size() != 0) begin errors++; $display("FAIL empty_beats got=%0d exp=0", got_data.size()); end
    if (bus.outbound_last !== 1'b0) begin errors++; $display("FAIL empty_last got=%b exp=0", bus.outbound_last); end
    if (bus.parse_error !== 1'b1) begin errors++; $display("FAIL empty_error got=%b exp=1", bus.parse_error); end
    if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", bus.instr_count); end
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; last_cyc = 0; nl2_cyc = 0;
    reset_n = 1'b0;
    bus.inbound_valid = 1'b0;
    bus.inbound_data  = 8'h00;
    @(negedge clk);
    test_reset();
    do_reset();
    test_single("single", 0, 1'b0);
    test_three_lines();
    test_back_to_back();
    test_malformed();
    test_async_reset();
    do_reset();
    test_single("crlf_gaps", 2, 1'b1);
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
